// File: rtl/hc165_pkg.sv
// hc165_pkg: shared state type and device constants for the HD74HC165 reader.
package hc165_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      PRIME = 2'd2,
      SHIFT = 2'd3
   } hc165_state_t;

   localparam int HC165_BITS    = 8;
   localparam int HC165_LAT_MAX = 3;

endpackage

// File: rtl/hc165_reader_chk.sv
// hc165_reader_chk: protocol invariants of the reader's registered device
// controls and result strobe.
module hc165_reader_chk (
   input  logic clk,
   input  logic rst_n,
   input  logic busy,
   input  logic valid,
   input  logic shift_load,
   input  logic clock_in_hibit
);

   // The device runs exactly while a capture is in progress.
   a_freeze_idle : assert property (@(posedge clk) disable iff (!rst_n)
      clock_in_hibit == !busy);

   a_load_busy : assert property (@(posedge clk) disable iff (!rst_n)
      !shift_load |-> busy);

   a_load_once : assert property (@(posedge clk) disable iff (!rst_n)
      !shift_load |=> shift_load);

   a_valid_idle : assert property (@(posedge clk) disable iff (!rst_n)
      valid |-> !busy);

   a_valid_pulse : assert property (@(posedge clk) disable iff (!rst_n)
      valid |=> !valid);

endmodule

// File: rtl/hc165_reader.sv
// hc165_reader: drives an HD74HC165 chain through load/prime/shift and
// reassembles the MSB-first qh stream into a parallel word.
module hc165_reader
   import hc165_pkg::*;
#(
   parameter int WIDTH = HC165_BITS,
   parameter int LAT   = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             qh,
   output logic             shift_load,
   output logic             clock_in_hibit,
   output logic             busy,
   output logic [WIDTH-1:0] data,
   output logic             valid
);

   localparam int CNT_W   = $clog2(WIDTH + 1);
   localparam int PRIME_W = $clog2(HC165_LAT_MAX + 1);

   localparam logic [CNT_W-1:0]   LAST_BIT   = CNT_W'(WIDTH - 1);
   localparam logic [PRIME_W-1:0] LAST_PRIME = (LAT > 0) ? PRIME_W'(LAT - 1) : {PRIME_W{1'b0}};
   localparam logic               HAS_PRIME  = (LAT > 0) ? 1'b1 : 1'b0;

   hc165_state_t       state_r, state_s;
   logic [CNT_W-1:0]   bit_cnt_r, bit_cnt_s;
   logic [PRIME_W-1:0] prime_cnt_r, prime_cnt_s;
   logic [WIDTH-1:0]   sreg_r, sreg_s;
   logic [WIDTH-1:0]   data_r, data_s;
   logic [WIDTH-1:0]   word_s;
   logic               valid_r, valid_s;
   logic               busy_r;
   logic               shift_load_r;
   logic               clock_in_hibit_r;

   // Next-state, sequencing counters and deserializer datapath.
   always_comb begin
      state_s     = state_r;
      bit_cnt_s   = bit_cnt_r;
      prime_cnt_s = prime_cnt_r;
      sreg_s      = sreg_r;
      data_s      = data_r;
      valid_s     = 1'b0;
      word_s      = {sreg_r[WIDTH-2:0], qh};

      case (state_r)
         IDLE: begin
            if (start) begin
               state_s     = LOAD;
               bit_cnt_s   = {CNT_W{1'b0}};
               prime_cnt_s = {PRIME_W{1'b0}};
            end else begin
               state_s = IDLE;
            end
         end
         LOAD: begin
            if (HAS_PRIME) begin
               state_s = PRIME;
            end else begin
               state_s = SHIFT;
            end
         end
         // qh still carries stale bits while the device output pipeline fills.
         PRIME: begin
            if (prime_cnt_r == LAST_PRIME) begin
               state_s = SHIFT;
            end else begin
               prime_cnt_s = prime_cnt_r + PRIME_W'(1);
            end
         end
         SHIFT: begin
            sreg_s    = word_s;
            bit_cnt_s = bit_cnt_r + CNT_W'(1);
            if (bit_cnt_r == LAST_BIT) begin
               data_s  = word_s;
               valid_s = 1'b1;
               state_s = IDLE;
            end else begin
               state_s = SHIFT;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State and datapath registers; device controls are registered from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r          <= IDLE;
         bit_cnt_r        <= {CNT_W{1'b0}};
         prime_cnt_r      <= {PRIME_W{1'b0}};
         sreg_r           <= {WIDTH{1'b0}};
         data_r           <= {WIDTH{1'b0}};
         valid_r          <= 1'b0;
         busy_r           <= 1'b0;
         shift_load_r     <= 1'b1;
         clock_in_hibit_r <= 1'b1;
      end else begin
         state_r          <= state_s;
         bit_cnt_r        <= bit_cnt_s;
         prime_cnt_r      <= prime_cnt_s;
         sreg_r           <= sreg_s;
         data_r           <= data_s;
         valid_r          <= valid_s;
         busy_r           <= (state_s != IDLE);
         shift_load_r     <= (state_s != LOAD);
         clock_in_hibit_r <= (state_s == IDLE);
      end
   end

   assign shift_load     = shift_load_r;
   assign clock_in_hibit = clock_in_hibit_r;
   assign busy           = busy_r;
   assign data           = data_r;
   assign valid          = valid_r;

   hc165_reader_chk u_chk (
      .clk            (clk),
      .rst_n          (rst_n),
      .busy           (busy_r),
      .valid          (valid_r),
      .shift_load     (shift_load_r),
      .clock_in_hibit (clock_in_hibit_r)
   );

endmodule

// File: tb/tb_hc165_reader.sv
// tb_hc165_reader: four readers (8b/LAT1, 16b chain/LAT1, 8b/LAT0, 8b/LAT2)
// each driving a behavioural HD74HC165 with the matching output delay.
module tb_hc165_reader;

   localparam int W8 = 8;
   localparam int L8 = 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic [7:0]  par8  = 8'h00;
   logic [15:0] par16 = 16'h0000;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic qh8, sl8, cih8, busy8, valid8;
   logic qh16, sl16, cih16, busy16, valid16;
   logic qh0, sl0, cih0, busy0, valid0;
   logic qh2, sl2, cih2, busy2, valid2;
   logic [7:0]  data8, data0, data2;
   logic [15:0] data16;

   hc165_reader #(.WIDTH(8), .LAT(1)) u8 (
      .clk(clk), .rst_n(rst_n), .start(start), .qh(qh8), .shift_load(sl8),
      .clock_in_hibit(cih8), .busy(busy8), .data(data8), .valid(valid8));
   hc165_reader #(.WIDTH(16), .LAT(1)) u16 (
      .clk(clk), .rst_n(rst_n), .start(start), .qh(qh16), .shift_load(sl16),
      .clock_in_hibit(cih16), .busy(busy16), .data(data16), .valid(valid16));
   hc165_reader #(.WIDTH(8), .LAT(0)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start), .qh(qh0), .shift_load(sl0),
      .clock_in_hibit(cih0), .busy(busy0), .data(data0), .valid(valid0));
   hc165_reader #(.WIDTH(8), .LAT(2)) u2 (
      .clk(clk), .rst_n(rst_n), .start(start), .qh(qh2), .shift_load(sl2),
      .clock_in_hibit(cih2), .busy(busy2), .data(data2), .valid(valid2));

   // Behavioural devices: load when shift_load=0, shift when not inhibited.
   logic [7:0] dev8 = 8'h00, dev0 = 8'h00, dev2 = 8'h00, dev_a = 8'h00, dev_b = 8'h00;
   logic q8_d = 1'b0, q16_d = 1'b0;
   logic [1:0] q2_d = 2'b00;

   always @(posedge clk) begin
      if (!sl8) dev8 <= par8; else if (!cih8) dev8 <= {dev8[6:0], 1'b0};
      q8_d <= dev8[7];
   end
   always @(posedge clk) begin
      if (!sl16) begin
         dev_a <= par16[15:8];
         dev_b <= par16[7:0];
      end else if (!cih16) begin
         dev_a <= {dev_a[6:0], dev_b[7]};
         dev_b <= {dev_b[6:0], 1'b0};
      end
      q16_d <= dev_a[7];
   end
   always @(posedge clk) begin
      if (!sl0) dev0 <= par8; else if (!cih0) dev0 <= {dev0[6:0], 1'b0};
   end
   always @(posedge clk) begin
      if (!sl2) dev2 <= par8; else if (!cih2) dev2 <= {dev2[6:0], 1'b0};
      q2_d <= {q2_d[0], dev2[7]};
   end
   assign qh8  = q8_d;
   assign qh16 = q16_d;
   assign qh0  = dev0[7];
   assign qh2  = q2_d[1];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 20)
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model for u8: capture rules in terms of the edge index of E0.
   typedef struct { int due; logic [7:0] word; } exp_t;
   exp_t exp_q[$];
   logic       m_busy = 1'b0;
   int         m_e0 = -100;
   logic [7:0] m_word = 8'h00;
   logic [7:0] m_last = 8'h00;

   initial begin
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            m_busy = 1'b0;
            m_last = 8'h00;
            exp_q.delete();
         end else if (!m_busy) begin
            if (start) begin
               m_busy = 1'b1;
               m_e0   = cyc;
            end
         end else begin
            if (cyc == m_e0 + 1) m_word = par8;
            if (cyc == m_e0 + 1 + L8 + W8) begin
               exp_q.push_back('{due: cyc, word: m_word});
               m_busy = 1'b0;
            end
         end
      end
   end

   // Cycle monitor for u8 against the model.
   initial begin
      logic exp_v;
      forever begin
         @(negedge clk);
         exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc - 1);
         chk("u8_valid", 32'(valid8), 32'(exp_v));
         if (exp_v) begin
            m_last = exp_q[0].word;
            void'(exp_q.pop_front());
         end
         chk("u8_data", 32'(data8), 32'(m_last));
         chk("u8_busy", 32'(busy8), 32'(m_busy));
         chk("u8_clock_in_hibit", 32'(cih8), 32'(!m_busy));
         chk("u8_shift_load", 32'(sl8), 32'(!(m_busy && (cyc - 1 == m_e0))));
      end
   end

   typedef struct {
      logic [7:0]  par;
      logic [7:0]  parb;
      logic [7:0]  exp8;
      logic [15:0] exp16;
   } vec_t;
   vec_t vecs[8];

   task automatic run_vec(input vec_t v);
      int e0;
      int t8, t16, t0, t2;
      int n8, n16, n0, n2;
      logic [7:0]  d8, d0, d2;
      logic [15:0] d16;
      t8 = -1; t16 = -1; t0 = -1; t2 = -1;
      n8 = 0; n16 = 0; n0 = 0; n2 = 0;
      d8 = 8'h00; d0 = 8'h00; d2 = 8'h00; d16 = 16'h0000;
      @(negedge clk); #2;
      par8 = v.par; par16 = {v.par, v.parb}; start = 1'b1;
      @(negedge clk);
      e0 = cyc - 1;
      #2 start = 1'b0;
      for (int i = 0; i < 26; i++) begin
         @(negedge clk);
         if (valid8)  begin n8++;  t8  = cyc - 1; d8  = data8;  end
         if (valid16) begin n16++; t16 = cyc - 1; d16 = data16; end
         if (valid0)  begin n0++;  t0  = cyc - 1; d0  = data0;  end
         if (valid2)  begin n2++;  t2  = cyc - 1; d2  = data2;  end
      end
      chk("vec_data_w8",   32'(d8),  32'(v.exp8));
      chk("vec_data_w16",  32'(d16), 32'(v.exp16));
      chk("vec_data_lat0", 32'(d0),  32'(v.exp8));
      chk("vec_data_lat2", 32'(d2),  32'(v.exp8));
      chk("vec_edge_w8",   t8 - e0,  32'd10);
      chk("vec_edge_w16",  t16 - e0, 32'd18);
      chk("vec_edge_lat0", t0 - e0,  32'd9);
      chk("vec_edge_lat2", t2 - e0,  32'd11);
      chk("vec_pulses", n8 + n16 + n0 + n2, 32'd4);
   endtask

   initial begin
      int e0;
      int nv;
      int tv[2];
      logic [7:0] dv[2];

      vecs[0] = '{8'hA5, 8'h5A, 8'hA5, 16'hA55A};
      vecs[1] = '{8'h80, 8'h00, 8'h80, 16'h8000};
      vecs[2] = '{8'h01, 8'h01, 8'h01, 16'h0101};
      vecs[3] = '{8'h12, 8'h34, 8'h12, 16'h1234};
      vecs[4] = '{8'h5A, 8'hC3, 8'h5A, 16'h5AC3};
      vecs[5] = '{8'hFF, 8'h00, 8'hFF, 16'hFF00};
      vecs[6] = '{8'h00, 8'hFF, 8'h00, 16'h00FF};
      vecs[7] = '{8'h3C, 8'h80, 8'h3C, 16'h3C80};

      repeat (3) @(negedge clk);
      chk("rst_shift_load",     32'(sl8),    32'd1);
      chk("rst_clock_in_hibit", 32'(cih8),   32'd1);
      chk("rst_busy",           32'(busy8),  32'd0);
      chk("rst_valid",          32'(valid8), 32'd0);
      chk("rst_data16",         32'(data16), 32'd0);
      #2 rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // Back-to-back with start held high; inputs change after the first load.
      nv = 0;
      tv[0] = -1; tv[1] = -1; dv[0] = 8'h00; dv[1] = 8'h00;
      @(negedge clk); #2;
      par8 = 8'h3C; start = 1'b1;
      @(negedge clk);
      e0 = cyc - 1;
      @(negedge clk); #2;
      par8 = 8'hC3;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (valid8 && nv < 2) begin
            tv[nv] = cyc - 1;
            dv[nv] = data8;
            nv++;
         end
         if (nv == 2) break;
      end
      #2 start = 1'b0;
      chk("b2b_count",  nv, 32'd2);
      chk("b2b_first",  32'(dv[0]), 32'h3C);
      chk("b2b_second", 32'(dv[1]), 32'hC3);
      chk("b2b_first_edge", tv[0] - e0, 32'd10);
      chk("b2b_period", tv[1] - tv[0], 32'(L8 + W8 + 2));
      repeat (30) @(negedge clk);

      // Reset in the middle of shifting out 8'hFF.
      @(negedge clk); #2;
      par8 = 8'hFF; par16 = 16'hFFFF; start = 1'b1;
      @(negedge clk); #2;
      start = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("abort_valid",          32'(valid8), 32'd0);
      chk("abort_data",           32'(data8),  32'd0);
      chk("abort_clock_in_hibit", 32'(cih8),   32'd1);
      chk("abort_shift_load",     32'(sl8),    32'd1);
      #2 rst_n = 1'b1;
      repeat (15) @(negedge clk);
      chk("abort_data_hold", 32'(data8), 32'd0);
      run_vec(vecs[0]);

      // Randomized traffic, including rare resets, checked by the model.
      for (int i = 0; i < 600; i++) begin
         @(negedge clk); #2;
         par8  = 8'($urandom);
         par16 = 16'($urandom);
         start = ($urandom_range(0, 3) == 0);
         rst_n = ($urandom_range(0, 249) != 0);
      end
      @(negedge clk); #2;
      start = 1'b0;
      rst_n = 1'b1;
      repeat (30) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
